// File: rtl/irq_pending_unit.sv
// Interrupt front end: synchronises raw lines, latches edges into pending
// bits, and turns controller completion pulses into clears and acks.
module irq_pending_unit #(
  parameter int N_IRQ       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_IRQ-1:0] irq_line_i,
  input  logic [N_IRQ-1:0] edge_mode_i,
  input  logic [N_IRQ-1:0] irq_ret_i,
  input  logic [N_IRQ-1:0] sw_clear_i,
  output logic [N_IRQ-1:0] irq_req_o,
  output logic [N_IRQ-1:0] irq_ack_o,
  output logic [N_IRQ-1:0] overrun_o
);

  logic [SYNC_STAGES-1:0][N_IRQ-1:0] r_sync;
  logic [N_IRQ-1:0] r_prev;
  logic [N_IRQ-1:0] r_mode;
  logic [N_IRQ-1:0] r_pend;
  logic [N_IRQ-1:0] r_ovr;
  logic [N_IRQ-1:0] r_ack;

  logic [N_IRQ-1:0] w_s;
  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] w_keep;
  logic [N_IRQ-1:0] w_clr;
  logic [N_IRQ-1:0] w_pend_nxt;
  logic [N_IRQ-1:0] w_ovr_nxt;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_prev;
  assign w_clr  = irq_ret_i | sw_clear_i;
  // Pending state only lives while a line stays in edge mode.
  assign w_keep = edge_mode_i & ~(edge_mode_i ^ r_mode);

  // A new edge beats a same-cycle clear, so no event is dropped.
  assign w_pend_nxt = w_keep & (w_rise | (r_pend & ~w_clr));
  assign w_ovr_nxt  = w_keep & ~sw_clear_i
                    & (r_ovr | (w_rise & r_pend & ~irq_ret_i));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= '0;
      r_prev <= '0;
      r_mode <= '0;
      r_pend <= '0;
      r_ovr  <= '0;
      r_ack  <= '0;
    end else begin
      r_sync[0] <= irq_line_i;
      for (int k = 1; k < SYNC_STAGES; k++)
        r_sync[k] <= r_sync[k-1];
      r_prev <= w_s;
      r_mode <= edge_mode_i;
      r_pend <= w_pend_nxt;
      r_ovr  <= w_ovr_nxt;
      r_ack  <= irq_ret_i;
    end
  end

  assign irq_req_o = (edge_mode_i & r_pend) | (~edge_mode_i & w_s);
  assign irq_ack_o = r_ack;
  assign overrun_o = r_ovr;

endmodule

// File: tb/tb_irq_pending_unit.sv
// Directed bench for irq_pending_unit with a queue-based scoreboard.
module tb_irq_pending_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] line, mode, ret, swc;
  logic [15:0] req, ack, ovr;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic [15:0] req;
    logic [15:0] ack;
    logic [15:0] ovr;
  } exp_t;

  exp_t sb[$];

  irq_pending_unit #(.N_IRQ(16), .SYNC_STAGES(2)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .irq_line_i (line),
    .edge_mode_i(mode),
    .irq_ret_i  (ret),
    .sw_clear_i (swc),
    .irq_req_o  (req),
    .irq_ack_o  (ack),
    .overrun_o  (ovr)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic push(string t, logic [15:0] r,
                      logic [15:0] a, logic [15:0] o);
    exp_t e;
    e.tag = t; e.req = r; e.ack = a; e.ovr = o;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    tests++;
    assert (sb.size() > 0) else begin
      fails++;
      $error("FAIL sb_empty got 0 entries want 1");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      assert (req === e.req) else begin
        fails++;
        $error("FAIL %s req got %h want %h", e.tag, req, e.req);
      end
      tests++;
      assert (ack === e.ack) else begin
        fails++;
        $error("FAIL %s ack got %h want %h", e.tag, ack, e.ack);
      end
      tests++;
      assert (ovr === e.ovr) else begin
        fails++;
        $error("FAIL %s ovr got %h want %h", e.tag, ovr, e.ovr);
      end
    end
  endtask

  // Pulse is high across exactly one sampling edge.
  task automatic pulse(logic [15:0] m);
    line = line | m;
    cyc();
    line = line & ~m;
  endtask

  initial begin
    rst = 1'b1; line = '0; mode = '0; ret = '0; swc = '0;
    line = 16'h0008;
    cyc(); cyc();
    push("reset", 16'h0, 16'h0, 16'h0);
    check();
    rst = 1'b0;

    // Level mode, line 3 held high through reset release
    push("lvl_1edge", 16'h0000, 16'h0, 16'h0);
    cyc(); check();
    push("lvl_2edge", 16'h0008, 16'h0, 16'h0);
    cyc(); check();
    line = 16'h0000;
    push("lvl_drop1", 16'h0008, 16'h0, 16'h0);
    cyc(); check();
    push("lvl_drop2", 16'h0000, 16'h0, 16'h0);
    cyc(); check();

    // Level-mode ret still yields one ack
    ret = 16'h0008;
    push("lvl_ack", 16'h0000, 16'h0008, 16'h0);
    cyc(); ret = '0; check();
    push("lvl_ack_end", 16'h0000, 16'h0000, 16'h0);
    cyc(); check();

    // Edge mode, line 5
    mode = 16'h0020;
    cyc();
    push("edge5_e1", 16'h0000, 16'h0, 16'h0);
    pulse(16'h0020); check();
    push("edge5_e2", 16'h0000, 16'h0, 16'h0);
    cyc(); check();
    push("edge5_e3", 16'h0020, 16'h0, 16'h0);
    cyc(); check();
    push("edge5_hold", 16'h0020, 16'h0, 16'h0);
    cyc(); cyc(); check();
    ret = 16'h0020;
    push("edge5_ret", 16'h0000, 16'h0020, 16'h0);
    cyc(); ret = '0; check();
    push("edge5_ack1", 16'h0000, 16'h0000, 16'h0);
    cyc(); check();

    // Edge mode line 0: merged events and overrun
    mode = 16'h0021;
    cyc();
    pulse(16'h0001); cyc(); cyc();
    push("ovr_first", 16'h0001, 16'h0, 16'h0000);
    check();
    cyc(); cyc(); cyc();
    pulse(16'h0001); cyc(); cyc();
    push("ovr_set", 16'h0001, 16'h0, 16'h0001);
    check();
    push("ovr_sticky", 16'h0001, 16'h0, 16'h0001);
    cyc(); check();
    swc = 16'h0001;
    push("ovr_swclr", 16'h0000, 16'h0, 16'h0000);
    cyc(); swc = '0; check();

    // Edge mode line 7: rise coincides with ret
    mode = 16'h0080;
    cyc();
    pulse(16'h0080); cyc(); cyc();
    push("l7_pend", 16'h0080, 16'h0, 16'h0);
    check();
    pulse(16'h0080); cyc();
    ret = 16'h0080;
    push("l7_setwins", 16'h0080, 16'h0080, 16'h0);
    cyc(); ret = '0; check();
    push("l7_ack1", 16'h0080, 16'h0000, 16'h0);
    cyc(); check();

    // Mode change drops line 7
    mode = 16'h0004;
    push("l7_modechg", 16'h0000, 16'h0, 16'h0);
    cyc(); check();

    // Reset mid-service: no ack
    pulse(16'h0004); cyc(); cyc();
    push("l2_pend", 16'h0004, 16'h0, 16'h0);
    check();
    rst = 1'b1; ret = 16'h0004;
    push("l2_rst", 16'h0000, 16'h0000, 16'h0);
    cyc(); rst = 1'b0; ret = '0; check();
    push("l2_rst_after", 16'h0000, 16'h0000, 16'h0);
    cyc(); check();

    // Mode toggle to level with line low
    cyc();
    pulse(16'h0004); cyc(); cyc();
    push("l2_pend2", 16'h0004, 16'h0, 16'h0);
    check();
    mode = 16'h0000;
    push("l2_tolevel", 16'h0000, 16'h0, 16'h0);
    cyc(); check();
    mode = 16'h0004;
    push("l2_back_edge", 16'h0000, 16'h0, 16'h0);
    cyc(); check();

    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL sb_drain got %0d entries want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
